// File: rtl/essential_bit_scheduler_if.sv
// Operand-in / beat-out handshake bundle for the essential-bit scheduler.
// master: operand fetch + shift-add lane side; slave: the scheduler itself.
interface essential_bit_scheduler_if #(
  parameter int W    = 16,
  parameter int IDXW = $clog2(W)
);
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_mask;
  logic            in_sign;
  logic            out_valid;
  logic            out_ready;
  logic [IDXW-1:0] out_idx;
  logic            out_sign;
  logic            out_last;
  logic            out_zero;
  logic            out_trunc;

  modport master (
    output in_valid, in_mask, in_sign, out_ready,
    input  in_ready, out_valid, out_idx, out_sign, out_last, out_zero, out_trunc
  );

  modport slave (
    input  in_valid, in_mask, in_sign, out_ready,
    output in_ready, out_valid, out_idx, out_sign, out_last, out_zero, out_trunc
  );
endinterface

// File: rtl/essential_bit_scheduler.sv
// Essential-bit scheduler: walks the set bits of an operand mask MSB first,
// emitting one leading-one index per beat to the bit-serial shift-add lane.
// A term budget caps the beats per operand; an all-zero mask gives one dummy beat.
// The next operand may be loaded in the last-beat cycle, so there is no bubble.
module essential_bit_scheduler #(
  parameter int W         = 16,
  parameter int IDXW      = $clog2(W),
  parameter int MAX_TERMS = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  essential_bit_scheduler_if.slave   bus,
  output logic                       busy
);

  localparam int CW = $clog2(MAX_TERMS + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [W-1:0]    residual;
  logic [W-1:0]    lead;
  logic [W-1:0]    residual_clr;
  logic [CW-1:0]   count;
  logic            sign_q;
  logic [IDXW-1:0] lz;
  logic            run;
  logic            at_budget;
  logic            last;
  logic            fire;
  logic            accept;

  // Leading-one encoder: the highest set bit wins because it is visited last.
  always_comb begin
    lz   = '0;
    lead = '0;
    for (int i = 0; i < W; i++) begin
      if (residual[i]) begin
        lz      = IDXW'(W - 1 - i);
        lead    = '0;
        lead[i] = 1'b1;
      end
    end
  end

  assign residual_clr = residual & ~lead;
  assign run          = (state == RUN) && !reset;
  assign at_budget    = (count == CW'(MAX_TERMS - 1));
  assign last         = (residual == '0) || (residual_clr == '0) || at_budget;

  assign bus.out_valid = run;
  assign bus.out_idx   = run ? lz : '0;
  assign bus.out_sign  = run && sign_q;
  assign bus.out_last  = run && last;
  assign bus.out_zero  = run && (residual == '0);
  assign bus.out_trunc = run && at_budget && (residual_clr != '0);

  // The last beat being taken frees the scheduler in the same cycle.
  assign bus.in_ready = !reset &&
                        ((state == IDLE) || ((state == RUN) && last && bus.out_ready));

  assign fire   = run && bus.out_ready;
  assign accept = bus.in_valid && bus.in_ready;
  assign busy   = (state == RUN);

  // Operand load, per-beat residual clearing and term counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      residual <= '0;
      count    <= '0;
      sign_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            residual <= bus.in_mask;
            sign_q   <= bus.in_sign;
            count    <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (fire) begin
            if (last) begin
              if (accept) begin
                residual <= bus.in_mask;
                sign_q   <= bus.in_sign;
                count    <= '0;
              end else begin
                residual <= '0;
                count    <= '0;
                state    <= IDLE;
              end
            end else begin
              residual <= residual_clr;
              count    <= count + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_essential_bit_scheduler.sv
// Bench for essential_bit_scheduler: two instances (term budget 16 and 4) share
// the stimulus; the selected one is compared each cycle against a beat-list model.
module tb_essential_bit_scheduler;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_mask;
  logic        in_sign;
  logic        out_ready;
  logic        sel;
  logic        busy16;
  logic        busy4;

  int total = 0;
  int bad   = 0;
  int mt    = 16;

  typedef struct packed {
    logic [3:0] idx;
    logic       sign;
    logic       last;
    logic       zero;
    logic       trunc;
  } beat_t;

  beat_t cur[$];

  essential_bit_scheduler_if #(.W(16)) if16 ();
  essential_bit_scheduler_if #(.W(16)) if4 ();

  assign if16.in_valid  = in_valid;
  assign if16.in_mask   = in_mask;
  assign if16.in_sign   = in_sign;
  assign if16.out_ready = out_ready;
  assign if4.in_valid   = in_valid;
  assign if4.in_mask    = in_mask;
  assign if4.in_sign    = in_sign;
  assign if4.out_ready  = out_ready;

  essential_bit_scheduler #(.W(16), .MAX_TERMS(16)) dut16 (
    .clk(clk), .reset(reset), .bus(if16), .busy(busy16)
  );

  essential_bit_scheduler #(.W(16), .MAX_TERMS(4)) dut4 (
    .clk(clk), .reset(reset), .bus(if4), .busy(busy4)
  );

  logic       m_in_ready, m_out_valid, m_sign, m_last, m_zero, m_trunc, m_busy;
  logic [3:0] m_idx;

  assign m_in_ready  = sel ? if4.in_ready  : if16.in_ready;
  assign m_out_valid = sel ? if4.out_valid : if16.out_valid;
  assign m_idx       = sel ? if4.out_idx   : if16.out_idx;
  assign m_sign      = sel ? if4.out_sign  : if16.out_sign;
  assign m_last      = sel ? if4.out_last  : if16.out_last;
  assign m_zero      = sel ? if4.out_zero  : if16.out_zero;
  assign m_trunc     = sel ? if4.out_trunc : if16.out_trunc;
  assign m_busy      = sel ? busy4         : busy16;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t budget=%0d)", tag, got, exp, $time, mt);
    end
  endtask

  // Beat list of one operand: set bits MSB first, capped at the budget.
  task automatic buildBeats(input logic [15:0] m, input logic s);
    int    n;
    int    k;
    int    take;
    beat_t b;
    n = 0;
    for (int p = 0; p < 16; p++) if (m[p]) n++;
    take = (n < mt) ? n : mt;
    if (n == 0) begin
      b = '{idx: 4'd0, sign: s, last: 1'b1, zero: 1'b1, trunc: 1'b0};
      cur.push_back(b);
    end else begin
      k = 0;
      for (int p = 15; p >= 0; p--) begin
        if (m[p] && k < take) begin
          b.idx   = 4'(15 - p);
          b.sign  = s;
          b.last  = (k == take - 1);
          b.zero  = 1'b0;
          b.trunc = (k == take - 1) && (n > mt);
          cur.push_back(b);
          k++;
        end
      end
    end
  endtask

  // Drive one cycle, check the selected DUT mid-cycle, then advance the model.
  task automatic applyStimulus(input logic rst, input logic v, input logic [15:0] m,
                               input logic s, input logic r);
    logic  exp_valid;
    logic  exp_ready;
    beat_t h;
    reset     = rst;
    in_valid  = v;
    in_mask   = m;
    in_sign   = s;
    out_ready = r;
    @(negedge clk);
    exp_valid = !rst && (cur.size() != 0);
    exp_ready = !rst && ((cur.size() == 0) || ((cur.size() == 1) && r));
    h = exp_valid ? cur[0] : '0;
    checkOutput("out_valid", 32'(m_out_valid), 32'(exp_valid));
    checkOutput("in_ready",  32'(m_in_ready),  32'(exp_ready));
    checkOutput("out_idx",   32'(m_idx),       32'(h.idx));
    checkOutput("out_sign",  32'(m_sign),      32'(exp_valid & h.sign));
    checkOutput("out_last",  32'(m_last),      32'(exp_valid & h.last));
    checkOutput("out_zero",  32'(m_zero),      32'(exp_valid & h.zero));
    checkOutput("out_trunc", 32'(m_trunc),     32'(exp_valid & h.trunc));
    if (!rst) checkOutput("busy", 32'(m_busy), 32'(cur.size() != 0));
    if (rst) begin
      cur.delete();
    end else begin
      if (exp_valid && r) void'(cur.pop_front());
      if (v && exp_ready) buildBeats(m, s);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
  endtask

  function automatic logic [15:0] randMask();
    logic [15:0] m;
    case ($urandom_range(0, 4))
      0:       m = 16'h0000;
      1:       m = 16'hFFFF;
      2:       m = 16'h0001 << $urandom_range(0, 15);
      3:       m = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      default: m = 16'($urandom);
    endcase
    return m;
  endfunction

  task automatic randomPhase(input int cycles);
    for (int i = 0; i < cycles; i++)
      applyStimulus(1'b0, 1'($urandom_range(0, 3) != 0), randMask(),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    idleCycles(20);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_mask = '0; in_sign = 1'b0; out_ready = 1'b0;
    sel = 1'b0; mt = 16;
    @(posedge clk);
    #1;
    $display("[TB] reset behaviour, budget 16");
    applyStimulus(1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);

    $display("[TB] two-bit operand with sign");
    applyStimulus(1'b0, 1'b1, 16'h8001, 1'b1, 1'b1);
    idleCycles(3);

    $display("[TB] zero mask");
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
    idleCycles(2);

    $display("[TB] stalls");
    applyStimulus(1'b0, 1'b1, 16'h0420, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    idleCycles(2);

    $display("[TB] back-to-back operands");
    applyStimulus(1'b0, 1'b1, 16'h0003, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h4000, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h4000, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    idleCycles(2);

    $display("[TB] reset mid-operand");
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h0010, 1'b1, 1'b1);
    idleCycles(3);

    $display("[TB] random traffic, budget 16");
    randomPhase(600);

    sel = 1'b1; mt = 4;
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    $display("[TB] budget 4 truncation");
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1);
    idleCycles(6);
    applyStimulus(1'b0, 1'b1, 16'h00F0, 1'b1, 1'b1);
    idleCycles(6);

    $display("[TB] random traffic, budget 4");
    randomPhase(600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
